// File: rtl/uart_pkg.sv
// Shared UART transmitter types and constants.
// Defining UART_TX_BREAK_EN adds the BREAK state to the FSM encoding.
package uart_pkg;
  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 9;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

`ifdef UART_TX_BREAK_EN
  typedef enum logic [2:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP, ST_BREAK} tx_state_e;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} tx_state_e;
`endif

  // 2'b11 is an alias for "no parity".
  function automatic logic par_enabled(input logic [1:0] cfg);
    return (cfg == PAR_EVEN) || (cfg == PAR_ODD);
  endfunction
endpackage

// File: rtl/uart_tx_hold.sv
// One-entry holding register for the UART transmitter: word plus its frame config.
module uart_tx_hold
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] data_i,
  input  logic                 valid_i,
  input  logic [1:0]           parity_i,
  input  logic                 stop2_i,
  input  logic                 take_i,
  output logic                 ready_o,
  output logic                 hold_valid_o,
  output logic [DATA_BITS-1:0] hold_data_o,
  output logic [1:0]           hold_parity_o,
  output logic                 hold_stop2_o
);
  logic                 valid_q;
  logic [DATA_BITS-1:0] data_q;
  logic [1:0]           parity_q;
  logic                 stop2_q;

  // Accept needs an empty slot and take needs a full one, so they never collide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q  <= 1'b0;
      data_q   <= '0;
      parity_q <= PAR_NONE;
      stop2_q  <= 1'b0;
    end else if (valid_i && !valid_q) begin
      valid_q  <= 1'b1;
      data_q   <= data_i;
      parity_q <= parity_i;
      stop2_q  <= stop2_i;
    end else if (take_i) begin
      valid_q  <= 1'b0;
    end
  end

  assign ready_o       = !valid_q;
  assign hold_valid_o  = valid_q;
  assign hold_data_o   = data_q;
  assign hold_parity_o = parity_q;
  assign hold_stop2_o  = stop2_q;
endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: per-word parity and stop-bit count, zero-gap back-to-back frames.
// Define UART_TX_BREAK_EN to add the break_req input and the BREAK line state.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 TX_baud_tick,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 data_valid,
  output logic                 data_ready,
  input  logic [1:0]           cfg_parity,
  input  logic                 cfg_stop2,
`ifdef UART_TX_BREAK_EN
  input  logic                 break_req,
`endif
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);
  localparam int              CNT_W    = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_BITS);

  tx_state_e            state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 par_en_q, par_bit_q, stop2_q;
  logic                 tx_q, busy_q, done_q;

  logic                 hold_valid, hold_stop2;
  logic [1:0]           hold_parity;
  logic [DATA_BITS-1:0] hold_data;
  logic                 brk, last_stop, take;

`ifdef UART_TX_BREAK_EN
  assign brk = break_req;
`else
  assign brk = 1'b0;
`endif

  // cnt_q is reused as the stop-bit index while in STOP.
  assign last_stop = (state_q == ST_STOP) && (cnt_q == {{(CNT_W-1){1'b0}}, stop2_q});
  assign take      = TX_baud_tick && hold_valid &&
                     (((state_q == ST_IDLE) && !brk) || last_stop);

  uart_tx_hold #(.DATA_BITS(DATA_BITS)) u_hold (
    .clk          (clk),
    .reset        (reset),
    .data_i       (data_in),
    .valid_i      (data_valid),
    .parity_i     (cfg_parity),
    .stop2_i      (cfg_stop2),
    .take_i       (take),
    .ready_o      (data_ready),
    .hold_valid_o (hold_valid),
    .hold_data_o  (hold_data),
    .hold_parity_o(hold_parity),
    .hold_stop2_o (hold_stop2)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (take) begin
        // Start bit, either from IDLE or straight after the previous last stop bit.
        tx_q      <= 1'b0;
        busy_q    <= 1'b1;
        done_q    <= last_stop;
        state_q   <= ST_DATA;
        cnt_q     <= '0;
        shift_q   <= hold_data;
        par_en_q  <= par_enabled(hold_parity);
        par_bit_q <= (hold_parity == PAR_ODD) ? ~^hold_data : ^hold_data;
        stop2_q   <= hold_stop2;
      end else if (TX_baud_tick) begin
        case (state_q)
          ST_IDLE: begin
            if (brk) begin
`ifdef UART_TX_BREAK_EN
              tx_q    <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= ST_BREAK;
`endif
            end
          end
          ST_DATA: begin
            if (cnt_q == CNT_LAST) begin
              cnt_q <= '0;
              if (par_en_q) begin
                tx_q    <= par_bit_q;
                state_q <= ST_PARITY;
              end else begin
                tx_q    <= 1'b1;
                state_q <= ST_STOP;
              end
            end else begin
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
              cnt_q   <= cnt_q + 1'b1;
            end
          end
          ST_PARITY: begin
            tx_q    <= 1'b1;
            state_q <= ST_STOP;
          end
          ST_STOP: begin
            if (last_stop) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
`ifdef UART_TX_BREAK_EN
          ST_BREAK: begin
            if (!brk) begin
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end
`endif
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame (legal 5..9).
REQ-002 SHALL have ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous reset, active-high.
- TX_baud_tick  input  1  one-cycle pulse per bit period.
- data_in  input  DATA_BITS  parallel word.
- data_valid  input  1  word offered.
- data_ready  output  1  holding slot free.
- cfg_parity  input  2  00 none, 01 even, 10 odd, 11 none.
- cfg_stop2  input  1  0 = one stop bit, 1 = two stop bits.
- tx  output  1  serial line, idle high.
- busy  output  1  frame in progress.
- frame_done  output  1  one-cycle pulse at the end of a frame.

Function
REQ-003 SHALL accept a word when data_valid && data_ready on a clk edge, capturing data_in, cfg_parity and cfg_stop2 together into a 1-entry holding register.
REQ-004 SHALL drive data_ready = !hold_valid, so it is low while the holding register is full.
REQ-005 SHALL use an FSM with states IDLE, DATA, PARITY, STOP, and BREAK (BREAK only when REQ-017 applies); tx, busy and frame_done SHALL be registered.
REQ-006 In IDLE, on a tick with hold_valid: SHALL set tx<=0 (start bit begins), load the shifter and frame config from the holding register, clear hold_valid, and go to DATA.
REQ-007 In DATA, each tick SHALL drive tx<=LSB and shift right; the tick driving bit DATA_BITS-1 completes DATA, and the next tick goes to PARITY if parity is enabled, else drives tx<=1 and enters STOP.
REQ-008 In PARITY, the tick SHALL drive tx<=parity, then the next tick drives tx<=1 and enters STOP.
- Even parity: parity = XOR of data.
- Odd parity: parity = XNOR of data.
REQ-009 In STOP, each tick SHALL end one stop bit; on the tick ending the last stop bit (1 or 2), frame_done SHALL pulse for one cycle.
REQ-010 On that same final tick, if hold_valid, the block SHALL behave as in REQ-006 (tx<=0, zero idle gap); otherwise tx SHALL stay 1 and the FSM SHALL go to IDLE.
REQ-011 Frame length in ticks SHALL be 1 + DATA_BITS + P + S, where P = 1 if parity is enabled else 0, and S = number of stop bits; frame_done occurs at tick index 1+DATA_BITS+P+S, counting the start tick as 0.
REQ-012 busy SHALL be high from the start tick until frame_done, inclusive of the frame_done cycle only if the next frame starts.
REQ-013 Non-tick cycles SHALL hold all state except holding-register acceptance; frame config SHALL be fixed for the whole frame.
REQ-014 The bit counter SHALL be ceil(log2(DATA_BITS+1)) bits wide and SHALL never wrap within a frame.

Reset
REQ-015 On reset assertion, SHALL asynchronously set tx=1, busy=0, frame_done=0, data_ready=1, hold_valid=0, state=IDLE, and clear the shifter; a frame in progress SHALL be abandoned.
REQ-016 After reset release, the first frame SHALL start no earlier than the first tick after a word is accepted.

Configuration
REQ-017 With UART_TX_BREAK_EN defined, the block SHALL add input break_req (1 bit) and state BREAK, which behaves as follows:
- In IDLE, a tick with break_req high (priority over hold_valid) SHALL set tx<=0 and enter BREAK.
- In BREAK, each tick with break_req high keeps tx low; a tick with break_req low sets tx<=1 and returns to IDLE.
- busy SHALL be high while in BREAK; frame_done SHALL not pulse.
REQ-018 Without UART_TX_BREAK_EN, break_req and BREAK SHALL be absent and behaviour SHALL be unchanged otherwise.

Structure
REQ-019 Shared package uart_pkg SHALL hold the FSM state typedef, the parity encoding constants (PAR_NONE, PAR_EVEN, PAR_ODD) and the DATA_BITS legal range constants.
REQ-020 The holding register and valid/ready logic SHALL be sub-module uart_tx_hold; the FSM and shifter SHALL remain in uart_tx_cfg.

Verification
REQ-021 The bench SHALL cover these scenarios:
- 8E1, data 0xA5: tx bits per tick T0..T10 = 0,1,0,1,0,0,1,0,1,0,1 (parity 0); frame_done at T11.
- 8N1, 0x00 then 0xFF offered back-to-back: second start bit at T10 with no high gap; frame_done at T10 and T20.
- DATA_BITS=5, odd parity, cfg_stop2=1, data 0x1F: start T0, data 1s T1..T5, parity 0 at T6, stop T7..T8, frame_done at T9.
- Backpressure: three words offered during a frame: data_ready low after the second is accepted; the third is accepted the cycle after the next frame's start tick; no word is lost or duplicated.
- Reset asserted at data bit 3: tx=1 within the same cycle, busy=0, data_ready=1; the next frame after release is correct.
- With UART_TX_BREAK_EN, break_req high for 12 ticks from IDLE with a pending word: tx low for 12 ticks, then high for 1 tick, then the pending frame's start bit.
